// File: rtl/dmem_arbiter_if.sv
// One requester's handshake bundle to the data-memory arbiter.
// The requester drives the request side; the arbiter drives grant and response.
interface dmem_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic                  lock;
  logic [31:0]           addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  gnt;
  logic                  rvalid;
  logic                  err;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req, we, lock, addr, wdata,
    input  gnt, rvalid, err, rdata
  );

  modport slave (
    input  req, we, lock, addr, wdata,
    output gnt, rvalid, err, rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter with bounded lock sequences sharing one single-port data memory
// between the load/store unit (m0) and the debug/DMA loader (m1).
module dmem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 32,
  parameter int LOCK_MAX   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  dmem_arbiter_if.slave         m0,
  dmem_arbiter_if.slave         m1,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(LOCK_MAX) + 1;

  typedef enum logic {ST_RR, ST_LOCKED} state_t;

  state_t           state_reg;
  logic             owner_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             last_reg;

  logic [1:0]            req_v;
  logic [1:0]            we_v;
  logic [1:0]            lock_v;
  logic [31:0]           addr_v  [2];
  logic [DATA_WIDTH-1:0] wdata_v [2];

  logic [1:0]            rvalid_reg;
  logic [1:0]            err_reg;
  logic [DATA_WIDTH-1:0] rdata_reg [2];

  logic             owner_hold;
  logic             gnt_any;
  logic             gnt_sel;
  logic [1:0]       gnt_v;
  logic [31:0]      sel_addr;
  logic             in_range;
  logic [CNT_W-1:0] cnt_inc;

  assign req_v   = {m1.req,  m0.req};
  assign we_v    = {m1.we,   m0.we};
  assign lock_v  = {m1.lock, m0.lock};
  assign addr_v[0]  = m0.addr;
  assign addr_v[1]  = m1.addr;
  assign wdata_v[0] = m0.wdata;
  assign wdata_v[1] = m1.wdata;

  // Grant depends only on requests and arbiter state, never on mem_rdata.
  always_comb begin
    owner_hold = (state_reg == ST_LOCKED) && req_v[owner_reg];
    gnt_any    = 1'b0;
    gnt_sel    = 1'b0;
    if (owner_hold) begin
      gnt_any = 1'b1;
      gnt_sel = owner_reg;
    end else if (req_v[0] && req_v[1]) begin
      gnt_any = 1'b1;
      gnt_sel = ~last_reg;
    end else if (req_v[0]) begin
      gnt_any = 1'b1;
      gnt_sel = 1'b0;
    end else if (req_v[1]) begin
      gnt_any = 1'b1;
      gnt_sel = 1'b1;
    end
    gnt_any = gnt_any & rst;
    gnt_v   = {gnt_any & gnt_sel, gnt_any & ~gnt_sel};
  end

  assign sel_addr  = addr_v[gnt_sel];
  assign in_range  = sel_addr < 32'(MEM_DEPTH);
  assign mem_we    = gnt_any & we_v[gnt_sel] & in_range;
  assign mem_addr  = gnt_any ? sel_addr : 32'd0;
  assign mem_wdata = gnt_any ? wdata_v[gnt_sel] : '0;
  assign cnt_inc   = cnt_reg + CNT_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_RR;
      owner_reg <= 1'b0;
      cnt_reg   <= '0;
      last_reg  <= 1'b1;
    end else if (gnt_any) begin
      last_reg <= gnt_sel;
      if (owner_hold) begin
        // Owner dropping lock or hitting the bound hands the next contention to the other port.
        if (!lock_v[owner_reg] || (cnt_inc >= CNT_W'(LOCK_MAX))) begin
          state_reg <= ST_RR;
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_inc;
        end
      end else if (lock_v[gnt_sel] && (LOCK_MAX > 1)) begin
        state_reg <= ST_LOCKED;
        owner_reg <= gnt_sel;
        cnt_reg   <= CNT_W'(1);
      end else begin
        state_reg <= ST_RR;
        cnt_reg   <= '0;
      end
    end else begin
      state_reg <= ST_RR;
      cnt_reg   <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid_reg   <= '0;
      err_reg      <= '0;
      rdata_reg[0] <= '0;
      rdata_reg[1] <= '0;
    end else begin
      rvalid_reg <= gnt_v;
      err_reg    <= gnt_v & {2{~in_range}};
      for (int p = 0; p < 2; p++) begin
        if (gnt_v[p]) begin
          if (!in_range) begin
            rdata_reg[p] <= '0;
          end else if (!we_v[p]) begin
            rdata_reg[p] <= mem_rdata;
          end
        end
      end
    end
  end

  assign m0.gnt    = gnt_v[0];
  assign m1.gnt    = gnt_v[1];
  assign m0.rvalid = rvalid_reg[0];
  assign m1.rvalid = rvalid_reg[1];
  assign m0.err    = err_reg[0];
  assign m1.err    = err_reg[1];
  assign m0.rdata  = rdata_reg[0];
  assign m1.rdata  = rdata_reg[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: reset, single-port access, contention,
// out-of-range, lock bound, early unlock and asynchronous reset during a lock.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [31:0] mem [32];

  int errors = 0;
  int checks = 0;

  dmem_arbiter_if #(.DATA_WIDTH(32)) m0_bus ();
  dmem_arbiter_if #(.DATA_WIDTH(32)) m1_bus ();

  dmem_arbiter #(.DATA_WIDTH(32), .MEM_DEPTH(32), .LOCK_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0        (m0_bus),
    .m1        (m1_bus),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: synchronous write, combinational read.
  always @(posedge clk) if (mem_we) mem[mem_addr[4:0]] <= mem_wdata;
  assign mem_rdata = (mem_addr < 32) ? mem[mem_addr[4:0]] : 32'd0;

  always @(posedge clk) begin
    if (m0_bus.gnt) $display("txn m0 %s addr=%0d wdata=%h lock=%0b", m0_bus.we ? "WR" : "RD", m0_bus.addr, m0_bus.wdata, m0_bus.lock);
    if (m1_bus.gnt) $display("txn m1 %s addr=%0d wdata=%h lock=%0b", m1_bus.we ? "WR" : "RD", m1_bus.addr, m1_bus.wdata, m1_bus.lock);
  end

  task automatic drive0(input logic req, input logic we, input logic lock, input logic [31:0] addr, input logic [31:0] wdata);
    m0_bus.req = req; m0_bus.we = we; m0_bus.lock = lock; m0_bus.addr = addr; m0_bus.wdata = wdata;
  endtask

  task automatic drive1(input logic req, input logic we, input logic lock, input logic [31:0] addr, input logic [31:0] wdata);
    m1_bus.req = req; m1_bus.we = we; m1_bus.lock = lock; m1_bus.addr = addr; m1_bus.wdata = wdata;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    drive0(0, 0, 0, 0, 0);
    drive1(0, 0, 0, 0, 0);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    // Write request from m0 during reset must not reach the memory.
    drive0(1, 1, 0, 3, 32'hAAAA_AAAA);
    drive1(1, 0, 0, 4, 0);
    rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk); #1;
    checks++; if (m0_bus.gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt0: got %b want 0", m0_bus.gnt); end
    checks++; if (m1_bus.gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt1: got %b want 0", m1_bus.gnt); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    checks++; if ({m0_bus.rvalid, m1_bus.rvalid} !== 2'b00) begin errors++; $display("FAIL rst_rvalid: got %b want 00", {m0_bus.rvalid, m1_bus.rvalid}); end
    checks++; if ({m0_bus.err, m1_bus.err} !== 2'b00) begin errors++; $display("FAIL rst_err: got %b want 00", {m0_bus.err, m1_bus.err}); end
    checks++; if (m0_bus.rdata !== 32'd0) begin errors++; $display("FAIL rst_rdata0: got %h want 0", m0_bus.rdata); end
    drive0(1, 0, 0, 3, 0);
    rst = 1'b1;
    #1;
    checks++; if ({m0_bus.gnt, m1_bus.gnt} !== 2'b10) begin errors++; $display("FAIL rel_first_gnt: got m0/m1=%b want 10", {m0_bus.gnt, m1_bus.gnt}); end
    @(posedge clk); #1;
    checks++; if ({m0_bus.rvalid, m1_bus.rvalid} !== 2'b10) begin errors++; $display("FAIL rel_first_rvalid: got %b want 10", {m0_bus.rvalid, m1_bus.rvalid}); end
    checks++; if (m0_bus.rdata !== 32'h1000_0003) begin errors++; $display("FAIL rel_rdata0: got %h want 10000003", m0_bus.rdata); end
    @(negedge clk); #1;
    checks++; if ({m0_bus.gnt, m1_bus.gnt} !== 2'b01) begin errors++; $display("FAIL rel_second_gnt: got m0/m1=%b want 01", {m0_bus.gnt, m1_bus.gnt}); end
    @(posedge clk); #1;
    checks++; if ({m0_bus.rvalid, m1_bus.rvalid} !== 2'b01) begin errors++; $display("FAIL rel_second_rvalid: got %b want 01", {m0_bus.rvalid, m1_bus.rvalid}); end
    checks++; if (m1_bus.rdata !== 32'h1000_0004) begin errors++; $display("FAIL rel_rdata1: got %h want 10000004", m1_bus.rdata); end
    idle_cycle();
  endtask

  task automatic test_single_port();
    @(negedge clk);
    drive0(1, 1, 0, 5, 32'hDEAD_BEEF);
    #1;
    checks++; if (m0_bus.gnt !== 1'b1) begin errors++; $display("FAIL wr_gnt0: got %b want 1", m0_bus.gnt); end
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL wr_mem_we: got %b want 1", mem_we); end
    checks++; if (mem_addr !== 32'd5) begin errors++; $display("FAIL wr_mem_addr: got %0d want 5", mem_addr); end
    checks++; if (mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_mem_wdata: got %h want deadbeef", mem_wdata); end
    @(posedge clk); #1;
    checks++; if (m0_bus.rvalid !== 1'b1 || m0_bus.err !== 1'b0) begin errors++; $display("FAIL wr_resp: got rvalid=%b err=%b want 1/0", m0_bus.rvalid, m0_bus.err); end
    checks++; if (m0_bus.rdata !== 32'h1000_0003) begin errors++; $display("FAIL wr_rdata_hold: got %h want 10000003", m0_bus.rdata); end
    @(negedge clk);
    drive0(1, 0, 0, 5, 0);
    #1;
    checks++; if (m0_bus.gnt !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL rd_gnt: got gnt=%b we=%b want 1/0", m0_bus.gnt, mem_we); end
    @(posedge clk); #1;
    checks++; if (m0_bus.rvalid !== 1'b1 || m0_bus.err !== 1'b0) begin errors++; $display("FAIL rd_resp: got rvalid=%b err=%b want 1/0", m0_bus.rvalid, m0_bus.err); end
    checks++; if (m0_bus.rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_rdata: got %h want deadbeef", m0_bus.rdata); end
    idle_cycle();
    checks++; if (m0_bus.rvalid !== 1'b0) begin errors++; $display("FAIL rd_strobe_len: got %b want 0", m0_bus.rvalid); end
    checks++; if (m0_bus.rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_rdata_keep: got %h want deadbeef", m0_bus.rdata); end
  endtask

  task automatic test_contention();
    logic exp = 1'b1;  // m0 was granted last, so m1 wins the first contention
    @(negedge clk);
    drive0(1, 0, 0, 6, 0);
    drive1(1, 0, 0, 7, 0);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++; if ({m1_bus.gnt, m0_bus.gnt} !== {exp, ~exp}) begin errors++; $display("FAIL cont_gnt[%0d]: got m1/m0=%b want %b", i, {m1_bus.gnt, m0_bus.gnt}, {exp, ~exp}); end
      @(posedge clk); #1;
      checks++; if ({m1_bus.rvalid, m0_bus.rvalid} !== {exp, ~exp}) begin errors++; $display("FAIL cont_rvalid[%0d]: got m1/m0=%b want %b", i, {m1_bus.rvalid, m0_bus.rvalid}, {exp, ~exp}); end
      if (exp) begin
        checks++; if (m1_bus.rdata !== 32'h1000_0007) begin errors++; $display("FAIL cont_rdata1[%0d]: got %h want 10000007", i, m1_bus.rdata); end
      end else begin
        checks++; if (m0_bus.rdata !== 32'h1000_0006) begin errors++; $display("FAIL cont_rdata0[%0d]: got %h want 10000006", i, m0_bus.rdata); end
      end
      exp = ~exp;
    end
    idle_cycle();
  endtask

  task automatic test_out_of_range();
    @(negedge clk);
    drive1(1, 1, 0, 40, 32'h0000_1234);
    #1;
    checks++; if (m1_bus.gnt !== 1'b1) begin errors++; $display("FAIL oor_gnt1: got %b want 1", m1_bus.gnt); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL oor_mem_we: got %b want 0", mem_we); end
    @(posedge clk); #1;
    checks++; if (m1_bus.rvalid !== 1'b1 || m1_bus.err !== 1'b1) begin errors++; $display("FAIL oor_resp: got rvalid=%b err=%b want 1/1", m1_bus.rvalid, m1_bus.err); end
    checks++; if (m1_bus.rdata !== 32'd0) begin errors++; $display("FAIL oor_rdata: got %h want 0", m1_bus.rdata); end
    @(negedge clk);
    drive1(1, 0, 0, 8, 0);
    #1;
    checks++; if (m1_bus.gnt !== 1'b1) begin errors++; $display("FAIL alias_gnt1: got %b want 1", m1_bus.gnt); end
    @(posedge clk); #1;
    checks++; if (m1_bus.err !== 1'b0) begin errors++; $display("FAIL alias_err: got %b want 0", m1_bus.err); end
    checks++; if (m1_bus.rdata !== 32'h1000_0008) begin errors++; $display("FAIL alias_rdata: got %h want 10000008", m1_bus.rdata); end
    idle_cycle();
  endtask

  task automatic test_lock_bound();
    logic [5:0] pattern = 6'b010000;  // bit i = 1 means m1 expected at cycle i
    @(negedge clk);
    drive0(1, 0, 1, 9, 0);
    drive1(1, 0, 0, 10, 0);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++; if ({m1_bus.gnt, m0_bus.gnt} !== {pattern[i], ~pattern[i]}) begin errors++; $display("FAIL lock_gnt[%0d]: got m1/m0=%b want %b", i, {m1_bus.gnt, m0_bus.gnt}, {pattern[i], ~pattern[i]}); end
      @(posedge clk); #1;
    end
    idle_cycle();
  endtask

  task automatic test_lock_early_release();
    @(negedge clk);
    drive1(1, 0, 0, 11, 0);
    @(posedge clk); #1;
    @(negedge clk);
    drive0(1, 0, 1, 9, 0);
    drive1(1, 0, 0, 10, 0);
    #1;
    checks++; if ({m1_bus.gnt, m0_bus.gnt} !== 2'b01) begin errors++; $display("FAIL early_gnt1st: got m1/m0=%b want 01", {m1_bus.gnt, m0_bus.gnt}); end
    @(posedge clk); #1;
    @(negedge clk);
    m0_bus.lock = 1'b0;
    #1;
    checks++; if ({m1_bus.gnt, m0_bus.gnt} !== 2'b01) begin errors++; $display("FAIL early_gnt2nd: got m1/m0=%b want 01", {m1_bus.gnt, m0_bus.gnt}); end
    @(posedge clk); #1;
    @(negedge clk); #1;
    checks++; if ({m1_bus.gnt, m0_bus.gnt} !== 2'b10) begin errors++; $display("FAIL early_gnt3rd: got m1/m0=%b want 10", {m1_bus.gnt, m0_bus.gnt}); end
    @(posedge clk); #1;
    checks++; if (m1_bus.rvalid !== 1'b1 || m1_bus.rdata !== 32'h1000_000A) begin errors++; $display("FAIL early_resp1: got rvalid=%b rdata=%h want 1/1000000a", m1_bus.rvalid, m1_bus.rdata); end
    idle_cycle();
  endtask

  task automatic test_async_reset_lock();
    @(negedge clk);
    drive1(1, 0, 1, 12, 0);
    #1;
    checks++; if (m1_bus.gnt !== 1'b1) begin errors++; $display("FAIL arst_lock_start: got %b want 1", m1_bus.gnt); end
    @(posedge clk); #1;
    @(negedge clk);
    drive0(1, 0, 0, 13, 0);
    #1;
    checks++; if ({m1_bus.gnt, m0_bus.gnt} !== 2'b10) begin errors++; $display("FAIL arst_owner_gnt: got m1/m0=%b want 10", {m1_bus.gnt, m0_bus.gnt}); end
    @(posedge clk); #1;
    checks++; if (m1_bus.rvalid !== 1'b1 || m1_bus.rdata !== 32'h1000_000C) begin errors++; $display("FAIL arst_pre_resp: got rvalid=%b rdata=%h want 1/1000000c", m1_bus.rvalid, m1_bus.rdata); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({m1_bus.rvalid, m0_bus.rvalid} !== 2'b00) begin errors++; $display("FAIL arst_rvalid: got %b want 00", {m1_bus.rvalid, m0_bus.rvalid}); end
    checks++; if (m1_bus.rdata !== 32'd0) begin errors++; $display("FAIL arst_rdata1: got %h want 0", m1_bus.rdata); end
    checks++; if ({m1_bus.gnt, m0_bus.gnt, mem_we} !== 3'b000) begin errors++; $display("FAIL arst_gnt_we: got %b want 000", {m1_bus.gnt, m0_bus.gnt, mem_we}); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if ({m1_bus.gnt, m0_bus.gnt} !== 2'b01) begin errors++; $display("FAIL arst_post_gnt: got m1/m0=%b want 01", {m1_bus.gnt, m0_bus.gnt}); end
    @(posedge clk); #1;
    checks++; if (m0_bus.rvalid !== 1'b1 || m0_bus.rdata !== 32'h1000_000D) begin errors++; $display("FAIL arst_post_resp: got rvalid=%b rdata=%h want 1/1000000d", m0_bus.rvalid, m0_bus.rdata); end
    @(negedge clk); #1;
    checks++; if ({m1_bus.gnt, m0_bus.gnt} !== 2'b10) begin errors++; $display("FAIL arst_post_gnt2: got m1/m0=%b want 10", {m1_bus.gnt, m0_bus.gnt}); end
    @(posedge clk); #1;
    idle_cycle();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + 32'(i);
    test_reset();
    test_single_port();
    test_contention();
    test_out_of_range();
    test_lock_bound();
    test_lock_early_release();
    test_async_reset_lock();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within 100000 time units");
    $fatal(1, "timeout");
  end

endmodule
